// File: rtl/pop_counter_seq.sv
// Sequential popcount: counts CHUNK bits of an accepted word per cycle and
// optionally accumulates the result into a saturating, clearable total.
module pop_counter_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    parameter int ACC_W = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             accum_en,
    input  logic                             clear,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(WIDTH+1)-1:0]       out_count,
    output logic [ACC_W-1:0]                 out_total,
    output logic                             out_sat,
    output logic                             busy
);
    localparam int CW = $clog2(WIDTH+1);
    localparam int N  = WIDTH / CHUNK;
    localparam int SW = $clog2(N+1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [SW-1:0]    step;
    logic             acc_mode;
    logic [ACC_W-1:0] total;
    logic             sat;
    logic [ACC_W:0]   sum_sat;

    function automatic logic [CW-1:0] chunk_pop(input logic [CHUNK-1:0] bits);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + CW'(bits[i]);
        end
        return n;
    endfunction

    // Returns {overflowed, clamped sum}; clamps to all-ones on overflow.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [CW-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(b);
        if (s[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return s;
    endfunction

    always_comb begin
        count_next = count + chunk_pop(shift[CHUNK-1:0]);
        sum_sat    = sat_add(total, count_next);
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_total = total;
    assign out_sat   = sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift     <= '0;
            count     <= '0;
            step      <= '0;
            acc_mode  <= 1'b0;
            total     <= '0;
            sat       <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift    <= in_data;
                        acc_mode <= accum_en;
                        count    <= '0;
                        step     <= '0;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    count <= count_next;
                    shift <= shift >> CHUNK;
                    step  <= step + 1'b1;
                    // Last chunk: publish the count and fold it into the total.
                    if (step == SW'(N-1)) begin
                        state     <= DONE;
                        out_count <= count_next;
                        if (acc_mode) begin
                            total <= sum_sat[ACC_W-1:0];
                            if (sum_sat[ACC_W]) sat <= 1'b1;
                        end else begin
                            total <= ACC_W'(count_next);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Clear wins over a simultaneous DONE-entry update.
            if (clear) begin
                total <= '0;
                sat   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pop_counter_seq.sv
// Directed bench for pop_counter_seq: scoreboard of expected results, one
// 16-bit-accumulator instance and one 4-bit-accumulator instance in lockstep.
module tb_pop_counter_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       accum_en;
    logic       clear;
    logic       out_ready;

    logic        in_ready, out_valid, out_sat, busy;
    logic [3:0]  out_count;
    logic [15:0] out_total;
    logic        in_ready4, out_valid4, out_sat4, busy4;
    logic [3:0]  out_count4;
    logic [3:0]  out_total4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  cnt;
        logic [15:0] tot;
        logic        sat;
        logic [3:0]  tot4;
        logic        sat4;
    } exp_t;
    exp_t sbq[$];

    logic [15:0] m_tot;
    logic        m_sat;
    logic [3:0]  m_tot4;
    logic        m_sat4;

    always #5 clk = ~clk;

    pop_counter_seq #(.WIDTH(8), .CHUNK(2), .ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .accum_en(accum_en), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_total(out_total), .out_sat(out_sat), .busy(busy)
    );

    pop_counter_seq #(.WIDTH(8), .CHUNK(2), .ACC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .accum_en(accum_en), .clear(clear),
        .out_valid(out_valid4), .out_ready(out_ready), .out_count(out_count4),
        .out_total(out_total4), .out_sat(out_sat4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = 0;
        for (int i = 0; i < 8; i++) if (d[i]) n++;
        return n;
    endfunction

    task automatic model_push(input logic [7:0] d, input logic acc);
        exp_t        e;
        logic [16:0] s;
        logic [4:0]  s4;
        e.cnt = popcount8(d);
        if (acc) begin
            s  = {1'b0, m_tot} + 17'(e.cnt);
            s4 = {1'b0, m_tot4} + 5'(e.cnt);
            if (s > 17'd65535) begin m_tot = 16'hFFFF; m_sat = 1'b1; end
            else m_tot = s[15:0];
            if (s4 > 5'd15) begin m_tot4 = 4'hF; m_sat4 = 1'b1; end
            else m_tot4 = s4[3:0];
        end else begin
            m_tot  = 16'(e.cnt);
            m_tot4 = e.cnt;
        end
        e.tot = m_tot; e.sat = m_sat; e.tot4 = m_tot4; e.sat4 = m_sat4;
        sbq.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_out_count"}, 32'(out_count), 32'd0);
        chk({tag, "_out_total"}, 32'(out_total), 32'd0);
        chk({tag, "_out_sat"},   32'(out_sat),   32'd0);
    endtask

    // Offer one word, check latency, optionally stall in DONE, then hand shake.
    task automatic send(input logic [7:0] d, input logic acc, input int hold, input logic rdy);
        exp_t e;
        int   lat;
        in_valid  = 1'b1;
        in_data   = d;
        accum_en  = acc;
        out_ready = rdy;
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        model_push(d, acc);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        e = sbq.pop_front();
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            step();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_count", 32'(out_count), 32'(e.cnt));
            chk("stall_total", 32'(out_total), 32'(e.tot));
        end
        in_valid = 1'b0;
        chk("out_count", 32'(out_count), 32'(e.cnt));
        chk("out_total", 32'(out_total), 32'(e.tot));
        chk("out_sat", 32'(out_sat), 32'(e.sat));
        chk("out_total4", 32'(out_total4), 32'(e.tot4));
        chk("out_sat4", 32'(out_sat4), 32'(e.sat4));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_count_hold", 32'(out_count), 32'(e.cnt));
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        m_tot = '0; m_sat = 1'b0; m_tot4 = '0; m_sat4 = 1'b0;
        chk("clear_total", 32'(out_total), 32'd0);
        chk("clear_sat", 32'(out_sat), 32'd0);
        chk("clear_total4", 32'(out_total4), 32'd0);
        chk("clear_sat4", 32'(out_sat4), 32'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; accum_en = 1'b0;
        clear = 1'b0; out_ready = 1'b0;
        m_tot = '0; m_sat = 1'b0; m_tot4 = '0; m_sat4 = 1'b0;
        step();
        step();
        check_reset_outputs("rst");
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Zero and all-ones words, out_ready held high throughout.
        send(8'h00, 1'b0, 0, 1'b1);
        send(8'hFF, 1'b0, 0, 1'b1);

        // Stall in DONE for 10 cycles with stray in_valid.
        send(8'h3C, 1'b0, 10, 1'b0);

        // Accumulate three full words, then a single count.
        pulse_clear();
        send(8'hFF, 1'b1, 0, 1'b0);
        send(8'hFF, 1'b1, 0, 1'b0);
        send(8'hFF, 1'b1, 0, 1'b0);
        send(8'h0F, 1'b0, 0, 1'b0);
        chk("acc_seq_total", 32'(out_total), 32'd4);

        // Saturation on the 4-bit accumulator, then clear.
        pulse_clear();
        send(8'hFF, 1'b1, 0, 1'b0);
        send(8'hFF, 1'b1, 0, 1'b0);
        chk("sat4_total", 32'(out_total4), 32'd15);
        chk("sat4_flag", 32'(out_sat4), 32'd1);
        pulse_clear();

        // Full sweep of input words in single-count mode.
        for (int v = 0; v < 256; v++) begin
            send(8'(v), 1'b0, 0, 1'b0);
            chk("sweep_total_eq_count", 32'(out_total), 32'(out_count));
        end

        // Reset two cycles into a word: everything drops at once, no result.
        in_valid = 1'b1; in_data = 8'hAA; accum_en = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        m_tot = '0; m_sat = 1'b0; m_tot4 = '0; m_sat4 = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("no_valid_after_reset", 32'(seen), 32'd0);
        send(8'h01, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pop_counter_seq.md
POP_COUNTER_SEQ -- requirements
Module: pop_counter_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input word width; legal values are >=2 and a multiple of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 2: bits counted per cycle; legal range is 1..WIDTH.
REQ-003 SHALL have parameter ACC_W, default 16: accumulator width.
REQ-004 SHALL define the derived constants CW = clog2(WIDTH+1) and N = WIDTH/CHUNK.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  in  1  input word offered.
REQ-008 in_ready  out  1  block can accept a word.
REQ-009 in_data  in  WIDTH  word to count.
REQ-010 accum_en  in  1  accumulate mode, sampled with in_data at accept.
REQ-011 clear  in  1  synchronous clear of the accumulator.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer takes the result.
REQ-014 out_count  out  CW  number of ones in the accepted word.
REQ-015 out_total  out  ACC_W  accumulated or single count.
REQ-016 out_sat  out  1  sticky flag: accumulator saturated.
REQ-017 busy  out  1  high in COUNT or DONE.

Function
REQ-018 SHALL implement the FSM states IDLE, COUNT and DONE.
REQ-019 IDLE: in_ready=1; in_valid=1 accepts the word: latch in_data into the shift register, latch accum_en, count:=0, go to COUNT.
REQ-020 COUNT: each cycle, count += popcount(shift[CHUNK-1:0]) and shift >>= CHUNK; after exactly N COUNT cycles go to DONE.
REQ-021 Latency SHALL be N cycles: for a word accepted at edge k, out_valid=1 after edge k+N (WIDTH=8, CHUNK=2: 4 cycles).
REQ-022 On DONE entry: if accum_en=1, total:=min(total+count, 2^ACC_W-1) and out_sat:=1 when the sum exceeds the maximum; if accum_en=0, total:=count and out_sat is unchanged.
REQ-023 DONE: out_valid=1; out_count and out_total SHALL stay stable until out_valid&&out_ready, then go to IDLE.
REQ-024 in_ready SHALL be 0 in COUNT and DONE; there is no overlap between words; the earliest next accept is the cycle after the handshake.
REQ-025 out_ready while not in DONE SHALL be ignored.
REQ-026 clear=1 in any state SHALL set total:=0 and out_sat:=0 at the edge.
REQ-027 When clear coincides with DONE entry, clear SHALL take priority: total=0 and out_sat=0; out_count is still valid.
REQ-028 clear SHALL NOT affect the FSM, the count or the handshake.
REQ-029 Arithmetic SHALL be unsigned; count never exceeds WIDTH, so it never overflows CW.
REQ-030 out_count and out_total SHALL hold their last values after the DONE handshake until the next DONE entry.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE and clear the shift register, count, total and out_sat.
REQ-032 While rst_n=0, outputs SHALL be: in_ready=1, out_valid=0, busy=0, out_count=0, out_total=0, out_sat=0.
REQ-033 Reset during COUNT or DONE SHALL discard the word in flight; no out_valid is produced for that word.
REQ-034 in_valid SHALL be ignored during reset; the first accept is possible on the first edge after rst_n rises.

Verification (WIDTH=8, CHUNK=2, ACC_W=16 unless stated)
REQ-035 Accept 0x00, then 0xFF, with out_ready=1: out_count=0 then 8; out_valid rises 4 cycles after each accept.
REQ-036 Sweep in_data 0..255 with accum_en=0: out_count matches a popcount model for every word; out_total equals out_count.
REQ-037 Hold out_ready=0 for 10 cycles in DONE: out_valid, out_count and out_total remain stable; in_ready=0; in_valid is ignored.
REQ-038 Accept 0xFF x3 with accum_en=1, then 0x0F with accum_en=0: out_total=8,16,24,4.
REQ-039 With ACC_W=4, accumulate 0xFF x2: out_total=8 then 15 with out_sat=1; then pulse clear: out_total=0, out_sat=0.
REQ-040 Assert rst_n=0 two cycles after accepting 0xAA: all outputs take reset values at once, no out_valid follows, and the next word 0x01 yields out_count=1.
